// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter for a shared 32-bit 8:1 mux, with a bounded hold time.
// It drives the mux select and registers the selected mux output for the current owner.
module mux_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [31:0] mux_result,
  output logic [2:0]  sel,
  output logic [7:0]  grant,
  output logic        busy,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [2:0]  data_src
);

  typedef enum logic {StIdle, StOwn} state_e;

  localparam logic [7:0] HoldMax  = 8'(MAX_HOLD);
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  grant_q, grant_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic [2:0]  dsrc_q, dsrc_d;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       others;
  logic       rel;

  // First set request scanning upward from ptr, wrapping past index 7.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + i[2:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign others = |(req & ~grant_q);
  // Comparing with >= lets a requester that shows up after saturation still force a release.
  assign rel    = !req[sel_q] || ((hold_q >= HoldLast) && others);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    hold_d   = hold_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    dsrc_d   = dsrc_q;
    unique case (state_q)
      StIdle: begin
        grant_d = 8'h00;
        if (found) begin
          state_d = StOwn;
          grant_d = 8'b1 << winner;
          sel_d   = winner;
          hold_d  = 8'd0;
        end
      end
      StOwn: begin
        if (rel) begin
          state_d = StIdle;
          grant_d = 8'h00;
          ptr_d   = sel_q + 3'd1;
        end else begin
          dout_d   = mux_result;
          dsrc_d   = sel_q;
          dvalid_d = 1'b1;
          hold_d   = (hold_q < HoldMax) ? hold_q + 8'd1 : hold_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= 3'd0;
      sel_q    <= 3'd0;
      grant_q  <= 8'h00;
      hold_q   <= 8'd0;
      dout_q   <= 32'd0;
      dvalid_q <= 1'b0;
      dsrc_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      dsrc_q   <= dsrc_d;
    end
  end

  assign sel        = sel_q;
  assign grant      = grant_q;
  assign busy       = (state_q == StOwn);
  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign data_src   = dsrc_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Randomized and directed bench for mux_bus_arbiter, compared each cycle with an integer
// owner/pointer reference model.
module tb_mux_bus_arbiter;

  localparam int MaxHold = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  req = 8'h00;
  logic [31:0] mux_result = 32'd0;
  logic [2:0]  sel;
  logic [7:0]  grant;
  logic        busy;
  logic [31:0] data_out;
  logic        data_valid;
  logic [2:0]  data_src;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          m_owner;
  int          m_ptr;
  int          m_held;
  int          m_sel;
  logic [31:0] m_dout;
  int          m_dsrc;
  int          m_dval;

  mux_bus_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .mux_result (mux_result),
    .sel        (sel),
    .grant      (grant),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_src   (data_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
    m_dout  = 32'd0;
    m_dsrc  = 0;
    m_dval  = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs present at the edge.
  task automatic model_step();
    if (m_owner < 0) begin
      m_dval = 0;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_sel   = c;
          m_held  = 0;
        end
      end
    end else begin
      logic [7:0] rest;
      rest = req & ~(8'd1 << m_owner);
      if (!req[m_owner] || (m_held >= MaxHold - 1 && rest != 8'd0)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_dval  = 0;
      end else begin
        m_dout = mux_result;
        m_dsrc = m_owner;
        m_dval = 1;
        if (m_held < MaxHold) m_held++;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
    check("grant", 32'(grant), 32'(eg));
    check("busy", 32'(busy), (m_owner < 0) ? 32'd0 : 32'd1);
    check("sel", 32'(sel), 32'(m_sel));
    check("data_out", data_out, m_dout);
    check("data_valid", 32'(data_valid), 32'(m_dval));
    check("data_src", 32'(data_src), 32'(m_dsrc));
  endtask

  // Returns at the falling edge so the caller can drive the next inputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] forced_seq [11];

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Single request, sample lands one edge after grant.
    req = 8'h08;
    mux_result = 32'hDEADBEEF;
    step();
    check("single_grant", 32'(grant), 32'h08);
    check("single_sel", 32'(sel), 32'd3);
    step();
    check("single_data", data_out, 32'hDEADBEEF);
    check("single_valid", 32'(data_valid), 32'd1);
    req = 8'h00;
    step();
    check("release_valid", 32'(data_valid), 32'd0);
    check("release_hold_data", data_out, 32'hDEADBEEF);
    step();

    // Round robin with a single owned cycle per owner.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] own;
      own = 8'd1 << (k % 8);
      mux_result = $urandom;
      step();
      check("rr_order", 32'(grant), 32'(own));
      mux_result = $urandom;
      step();
      req = 8'hFF & ~own;
      step();
      check("rr_idle_gap", 32'(grant), 32'h00);
      req = 8'hFF;
    end

    // Forced release after MaxHold owned cycles.
    forced_seq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20,
                   8'h00, 8'h01};
    req = 8'h00;
    do_reset();
    req = 8'h21;
    for (int k = 0; k < 11; k++) begin
      step();
      check("forced_seq", 32'(grant), 32'(forced_seq[k]));
    end

    // No contention: saturated hold never releases.
    req = 8'h00;
    step();
    step();
    req = 8'h04;
    step();
    for (int k = 0; k < 20; k++) begin
      mux_result = $urandom;
      step();
      check("nocont_busy", 32'(busy), 32'd1);
    end
    // A late contender still forces the saturated owner out.
    req = 8'h14;
    step();
    check("late_force", 32'(grant), 32'h00);
    step();
    check("late_winner", 32'(grant), 32'h10);

    // Wrap from owner 7 back to 0.
    req = 8'h00;
    do_reset();
    req = 8'h80;
    step();
    step();
    req = 8'h01;
    step();
    step();
    check("wrap_grant", 32'(grant), 32'h01);

    // Asynchronous reset between edges.
    req = 8'h10;
    do_reset();
    step();
    step();
    check("pre_async", 32'(grant), 32'h10);
    #2;
    reset = 1'b1;
    #1;
    check("async_grant", 32'(grant), 32'h00);
    check("async_busy", 32'(busy), 32'd0);
    check("async_valid", 32'(data_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    check("post_async", 32'(grant), 32'h10);

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom & $urandom);
      mux_result = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
